// File: rtl/branch_cmp_pkg.sv
// Shared definitions for the multi-cycle branch-condition unit.
//   - funct3 encodings of the RISC-V conditional branches
//   - FSM state type {IDLE, SCAN, DONE}
//   - helpers that decode the branch decision and the illegal-funct3 case
package branch_cmp_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // 010 and 011 carry no branch meaning.
  function automatic logic is_illegal(input logic [2:0] f3);
    return (f3[2:1] == 2'b01);
  endfunction

  // Signed comparison applies only to BLT/BGE.
  function automatic logic is_signed_f3(input logic [2:0] f3);
    return (f3[2:1] == 2'b10);
  endfunction

  // Branch decision from the final equal/less flags. Illegal encodings never branch.
  function automatic logic taken_decode(input logic [2:0] f3, input logic eq, input logic lt);
    logic t;
    case (f3)
      F3_BEQ:           t = eq;
      F3_BNE:           t = ~eq;
      F3_BLT, F3_BLTU:  t = lt;
      F3_BGE, F3_BGEU:  t = ~lt;
      default:          t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/branch_compare_seq_if.sv
// Request/response bundle of branch_compare_seq.
//   master: the requester (drives request fields and out_ready)
//   slave : the compare unit (drives in_ready and the result fields)
interface branch_compare_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       funct3;
  logic             out_valid;
  logic             out_ready;
  logic             g;
  logic             l;
  logic             e;
  logic             taken;
  logic             illegal;

  modport master (
    output in_valid, a, b, funct3, out_ready,
    input  in_ready, out_valid, g, l, e, taken, illegal
  );

  modport slave (
    input  in_valid, a, b, funct3, out_ready,
    output in_ready, out_valid, g, l, e, taken, illegal
  );
endinterface

// File: rtl/comparator_n_bit.sv
// Combinational N-bit magnitude comparator.
//   a, b          : operands
//   sign_n_unsign : 1 = two's-complement compare, 0 = unsigned compare
//   g / l / e     : a > b, a < b, a == b (exactly one is set)
module comparator_n_bit #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sign_n_unsign,
  output logic         g,
  output logic         l,
  output logic         e
);

  logic signed [N-1:0] a_s;
  logic signed [N-1:0] b_s;
  logic                lt;

  assign a_s = a;
  assign b_s = b;
  assign lt  = sign_n_unsign ? (a_s < b_s) : (a < b);
  assign e   = (a == b);
  assign l   = lt;
  assign g   = ~lt & ~(a == b);

endmodule

// File: rtl/branch_compare_seq.sv
// Multi-cycle branch-condition unit for the execute stage.
// Compares rs1/rs2 CHUNK bits per cycle starting at the MSB chunk and stops on the
// first differing chunk, then presents g/l/e, taken and illegal until consumed.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of branch_compare_seq_if (request handshake, operands,
//                funct3, result handshake and result flags)
// WIDTH must be a multiple of CHUNK.
module branch_compare_seq
  import branch_cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  branch_compare_seq_if.slave bus
);

  localparam int NCH   = WIDTH / CHUNK;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCH - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2:0]         f3_q, f3_d;
  logic               g_q, g_d;
  logic               l_q, l_d;
  logic               e_q, e_d;
  logic               taken_q, taken_d;
  logic               illegal_q, illegal_d;

  logic [CHUNK-1:0]   chunk_a, chunk_b;
  logic               cmp_sign, cmp_g, cmp_l, cmp_e;

  // Select the chunk currently under comparison.
  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    for (int i = 0; i < NCH; i++) begin
      if (idx_q == IDX_W'(i)) begin
        chunk_a = a_q[i*CHUNK +: CHUNK];
        chunk_b = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  // Only the MSB chunk carries the sign; lower chunks are plain magnitudes.
  assign cmp_sign = is_signed_f3(f3_q) && (idx_q == IDX_LAST);

  comparator_n_bit #(.N(CHUNK)) u_cmp (
    .a             (chunk_a),
    .b             (chunk_b),
    .sign_n_unsign (cmp_sign),
    .g             (cmp_g),
    .l             (cmp_l),
    .e             (cmp_e)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    f3_d      = f3_q;
    g_d       = g_q;
    l_d       = l_q;
    e_d       = e_q;
    taken_d   = taken_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = SCAN;
          a_d     = bus.a;
          b_d     = bus.b;
          f3_d    = bus.funct3;
          idx_d   = IDX_LAST;
        end
      end
      SCAN: begin
        if (!cmp_e) begin
          // First differing chunk decides the whole comparison.
          g_d       = cmp_g;
          l_d       = cmp_l;
          e_d       = 1'b0;
          taken_d   = taken_decode(f3_q, 1'b0, cmp_l);
          illegal_d = is_illegal(f3_q);
          state_d   = DONE;
        end else if (idx_q == '0) begin
          g_d       = 1'b0;
          l_d       = 1'b0;
          e_d       = 1'b1;
          taken_d   = taken_decode(f3_q, 1'b1, 1'b0);
          illegal_d = is_illegal(f3_q);
          state_d   = DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d   = IDLE;
          g_d       = 1'b0;
          l_d       = 1'b0;
          e_d       = 1'b0;
          taken_d   = 1'b0;
          illegal_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      g_q       <= 1'b0;
      l_q       <= 1'b0;
      e_q       <= 1'b0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      g_q       <= g_d;
      l_q       <= l_d;
      e_q       <= e_d;
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
    end
  end

  // Operand latches need no reset: they are only read after an accept loads them.
  always_ff @(posedge clk) begin
    a_q  <= a_d;
    b_q  <= b_d;
    f3_q <= f3_d;
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.g         = g_q;
  assign bus.l         = l_q;
  assign bus.e         = e_q;
  assign bus.taken     = taken_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_branch_compare_seq.sv
module tb_branch_compare_seq;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int NCH   = WIDTH / CHUNK;

  typedef struct {
    logic g;
    logic l;
    logic e;
    logic taken;
    logic illegal;
    int   lat;
    string name;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  exp_t sb_q[$];

  branch_compare_seq_if #(.WIDTH(WIDTH)) bif ();

  branch_compare_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: full-width compare, then scan-latency from first differing chunk.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] f3, input string name);
    exp_t x;
    logic sgn, lt, eq;
    int first;
    sgn = (f3 == 3'b100) || (f3 == 3'b101);
    eq  = (a == b);
    lt  = sgn ? ($signed(a) < $signed(b)) : (a < b);
    x.e = eq;
    x.l = lt;
    x.g = !eq && !lt;
    x.illegal = (f3 == 3'b010) || (f3 == 3'b011);
    case (f3)
      3'b000: x.taken = eq;
      3'b001: x.taken = !eq;
      3'b100, 3'b110: x.taken = lt;
      3'b101, 3'b111: x.taken = !lt;
      default: x.taken = 1'b0;
    endcase
    first = -1;
    for (int i = NCH - 1; i >= 0; i--)
      if (first < 0 && a[i*CHUNK +: CHUNK] != b[i*CHUNK +: CHUNK]) first = i;
    x.lat  = (first < 0) ? NCH : 1 + (NCH - 1 - first);
    x.name = name;
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a request and push its expected result.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                      input string name);
    int n;
    n = 0;
    while (!bif.in_ready && n < 50) begin
      tick();
      n++;
    end
    chk({name, "_in_ready"}, bif.in_ready, 1'b1);
    bif.in_valid = 1'b1;
    bif.a        = a;
    bif.b        = b;
    bif.funct3   = f3;
    tick();
    bif.in_valid = 1'b0;
    bif.a        = $urandom;
    bif.b        = $urandom;
    sb_q.push_back(model(a, b, f3, name));
  endtask

  // Wait for the result, compare against the scoreboard head, hold, then consume.
  task automatic collect(input int hold);
    exp_t x;
    int   n;
    logic [4:0] snap;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 1'b1, 1'b0);
      return;
    end
    x = sb_q.pop_front();
    n = 0;
    do begin
      if (n > 0 || 1'b1) begin end
      if (bif.out_valid) break;
      tick();
      n++;
    end while (n < 40);
    chk({x.name, "_out_valid"}, bif.out_valid, 1'b1);
    chk({x.name, "_latency"}, n, x.lat);
    chk({x.name, "_g"}, bif.g, x.g);
    chk({x.name, "_l"}, bif.l, x.l);
    chk({x.name, "_e"}, bif.e, x.e);
    chk({x.name, "_taken"}, bif.taken, x.taken);
    chk({x.name, "_illegal"}, bif.illegal, x.illegal);
    chk({x.name, "_busy"}, bif.in_ready, 1'b0);
    snap = {bif.g, bif.l, bif.e, bif.taken, bif.illegal};
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({x.name, "_hold_valid"}, bif.out_valid, 1'b1);
      chk({x.name, "_hold_flags"}, {bif.g, bif.l, bif.e, bif.taken, bif.illegal}, snap);
      chk({x.name, "_hold_busy"}, bif.in_ready, 1'b0);
    end
    bif.out_ready = 1'b1;
    tick();
    bif.out_ready = 1'b0;
    chk({x.name, "_post_valid"}, bif.out_valid, 1'b0);
    chk({x.name, "_post_ready"}, bif.in_ready, 1'b1);
    chk({x.name, "_post_flags"}, {bif.g, bif.l, bif.e, bif.taken, bif.illegal}, 5'b0);
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                     input string name, input int hold);
    send(a, b, f3, name);
    collect(hold);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rf;
    logic [2:0]  f3tab [6];
    n_vec = 0;
    n_err = 0;
    f3tab[0] = 3'b000; f3tab[1] = 3'b001; f3tab[2] = 3'b100;
    f3tab[3] = 3'b101; f3tab[4] = 3'b110; f3tab[5] = 3'b111;

    rst_n         = 1'b0;
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b0;
    bif.a         = '0;
    bif.b         = '0;
    bif.funct3    = 3'b000;
    tick();
    tick();
    chk("rst_out_valid", bif.out_valid, 1'b0);
    chk("rst_flags", {bif.g, bif.l, bif.e, bif.taken, bif.illegal}, 5'b0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", bif.in_ready, 1'b1);

    run(32'h1234_5678, 32'h1234_5678, 3'b000, "beq_eq", 0);
    run(32'h8000_0000, 32'h0000_0001, 3'b100, "blt_neg", 0);
    run(32'h8000_0000, 32'h0000_0001, 3'b110, "bltu_big", 0);
    run(32'h0000_00FF, 32'h0000_00FE, 3'b111, "bgeu_lsb", 0);
    run(32'h0000_00FF, 32'h0000_00FE, 3'b001, "bne_lsb", 0);
    run(32'h0000_0001, 32'h0000_0002, 3'b010, "illegal010", 0);
    run(32'h0000_0005, 32'h0000_0002, 3'b011, "illegal011", 0);
    run(32'hFFFF_FF00, 32'hFFFF_FF01, 3'b101, "bge_negneg", 0);
    run(32'h0012_3400, 32'h0012_3500, 3'b101, "bge_mid", 0);
    run(32'h7FFF_FFFF, 32'h8000_0000, 3'b101, "bge_pos_neg", 5);

    // Reset in the middle of a scan: request abandoned, no result emitted.
    bif.in_valid = 1'b1;
    bif.a        = 32'hCAFE_F00D;
    bif.b        = 32'hCAFE_F00D;
    bif.funct3   = 3'b000;
    tick();
    bif.in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bif.out_valid, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_in_ready", bif.in_ready, 1'b1);
    for (int i = 0; i < NCH + 2; i++) begin
      chk("midrst_no_stale", bif.out_valid, 1'b0);
      tick();
    end
    run(32'h0000_0010, 32'h0000_0020, 3'b110, "after_rst", 0);

    // Random operands, biased so chunk-level equality and late differences occur.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case (i % 4)
        0: rb = $urandom;
        1: rb = ra ^ (32'h1 << $urandom_range(0, 31));
        2: rb = ra;
        default: rb = {ra[31:8], 8'($urandom)};
      endcase
      rf = (i % 7 == 6) ? 3'b010 : f3tab[$urandom_range(0, 5)];
      run(ra, rb, rf, "rand", i % 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
